// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the RAM arbiter: owner encoding and default RAM address width.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 13;

  localparam logic OWNER_P0 = 1'b0;
  localparam logic OWNER_P1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/grant/read-data bundle between two bus masters, the arbiter and the RAM macro.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [7:0]        p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [7:0]        p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;

  logic [7:0]        rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_w_en;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  ram_dout,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
    output rdata, ram_addr, ram_w_en, ram_din
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output ram_dout,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
    input  rdata, ram_addr, ram_w_en, ram_din
  );

endinterface

// File: rtl/ram_arb_grant.sv
// Priority select p0 over p1, zero-cycle grant; with RAM_ARB_FAIRNESS_EN a saturating
// starvation counter forces a p1 slot once p1 has waited STARVE_LIMIT cycles.
module ram_arb_grant
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
`ifdef RAM_ARB_FAIRNESS_EN
  input  logic clk,
`endif
  input  logic rst_n,
  input  logic p0_req,
  input  logic p1_req,
  output logic winner,
  output logic any_grant
);

  logic force_p1;

`ifdef RAM_ARB_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;

  assign force_p1 = (starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_n || !p1_req || (any_grant && winner == OWNER_P1)) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_p1 = 1'b0;
`endif

  // Nothing is granted while reset is held, so no write can slip through.
  always_comb begin
    any_grant = rst_n && (p0_req || p1_req);
    winner    = OWNER_P0;
    if (p1_req && (!p0_req || force_p1)) begin
      winner = OWNER_P1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between CPU (p0) and a secondary master (p1); fairness via RAM_ARB_FAIRNESS_EN.
// Grant in the request cycle, rvalid one cycle after a read grant; losers simply hold req.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  logic              winner;
  logic              any_grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [ADDR_W-1:0] addr_q;
  logic              tag_vld;
  logic              tag_owner;

  ram_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
`ifdef RAM_ARB_FAIRNESS_EN
    .clk       (clk),
`endif
    .rst_n     (rst_n),
    .p0_req    (bus.p0_req),
    .p1_req    (bus.p1_req),
    .winner    (winner),
    .any_grant (any_grant)
  );

  always_comb begin
    sel_we    = (winner == OWNER_P1) ? bus.p1_we    : bus.p0_we;
    sel_addr  = (winner == OWNER_P1) ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = (winner == OWNER_P1) ? bus.p1_wdata : bus.p0_wdata;
    // Idle cycles keep the address stable so the RAM output does not churn.
    ram_addr_c = any_grant ? sel_addr : addr_q;
  end

  assign bus.p0_gnt   = any_grant && (winner == OWNER_P0);
  assign bus.p1_gnt   = any_grant && (winner == OWNER_P1);
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_w_en = any_grant && sel_we;
  assign bus.ram_din  = any_grant ? sel_wdata : 8'h00;
  assign bus.rdata    = bus.ram_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      tag_vld   <= 1'b0;
      tag_owner <= OWNER_P0;
    end else begin
      addr_q    <= ram_addr_c;
      tag_vld   <= any_grant && !sel_we;
      tag_owner <= winner;
    end
  end

  // Gated by rst_n so a tag left over from before reset never surfaces.
  assign bus.p0_rvalid = rst_n && tag_vld && (tag_owner == OWNER_P0);
  assign bus.p1_rvalid = rst_n && tag_vld && (tag_owner == OWNER_P1);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int ADDR_W       = 13;
  localparam int STARVE_LIMIT = 8;
`ifdef RAM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ram_arbiter #(
    .ADDR_W       (ADDR_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM macro: registered read, write on ram_w_en.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_w_en) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  // Reference model state
  logic [7:0]        ref_mem [0:(1<<ADDR_W)-1];
  bit                pend_vld;
  bit                pend_owner;
  logic [7:0]        pend_data;
  int                starve;
  logic [ADDR_W-1:0] last_addr;
  bit                g0_prev, g1_prev;
  int                p1_gnt_count;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_p0(input bit req, input bit we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
  endtask

  task automatic set_p1(input bit req, input bit we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic run_cycle();
    bit                e_g0, e_g1, e_we, e_rv0, e_rv1;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_din;
    @(negedge clk);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (rst_n) begin
      if (bus.p1_req && (!bus.p0_req || (FAIR && starve >= STARVE_LIMIT))) e_g1 = 1'b1;
      else if (bus.p0_req) e_g0 = 1'b1;
    end
    e_we   = e_g0 ? bus.p0_we : (e_g1 ? bus.p1_we : 1'b0);
    e_addr = e_g0 ? bus.p0_addr : (e_g1 ? bus.p1_addr : last_addr);
    e_din  = (e_g0 || e_g1) ? (e_g0 ? bus.p0_wdata : bus.p1_wdata) : 8'h00;
    e_rv0  = rst_n && pend_vld && !pend_owner;
    e_rv1  = rst_n && pend_vld && pend_owner;

    check("p0_gnt", 32'(bus.p0_gnt), 32'(e_g0));
    check("p1_gnt", 32'(bus.p1_gnt), 32'(e_g1));
    check("ram_w_en", 32'(bus.ram_w_en), 32'(e_we));
    check("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
    check("ram_din", 32'(bus.ram_din), 32'(e_din));
    check("p0_rvalid", 32'(bus.p0_rvalid), 32'(e_rv0));
    check("p1_rvalid", 32'(bus.p1_rvalid), 32'(e_rv1));
    if (e_rv0 || e_rv1) check("rdata", 32'(bus.rdata), 32'(pend_data));

    if (!rst_n) begin
      pend_vld  = 1'b0;
      starve    = 0;
      last_addr = '0;
    end else begin
      pend_vld = 1'b0;
      if (e_g0 || e_g1) begin
        if (e_we) begin
          ref_mem[e_addr] = e_din;
        end else begin
          pend_vld   = 1'b1;
          pend_owner = e_g1;
          pend_data  = ref_mem[e_addr];
        end
      end
      if (!bus.p1_req || e_g1) starve = 0;
      else if (starve < STARVE_LIMIT) starve++;
      last_addr = e_addr;
    end
    g0_prev = e_g0;
    g1_prev = e_g1;
    if (e_g1) p1_gnt_count++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[16'h0010] = 8'hA5;
    ref_mem[16'h0010] = 8'hA5;
    pend_vld = 1'b0; pend_owner = 1'b0; pend_data = 8'h00;
    starve = 0; last_addr = '0; g0_prev = 1'b0; g1_prev = 1'b0; p1_gnt_count = 0;
    set_p0(1'b0, 1'b0, '0, 8'h00);
    set_p1(1'b0, 1'b0, '0, 8'h00);

    // Reset: outputs idle, ram_addr cleared
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_cycle();
    rst_n = 1'b1;
    run_cycle();

    // p0 read of preloaded 0x0010
    set_p0(1'b1, 1'b0, 13'h0010, 8'h00);
    run_cycle();
    set_p0(1'b0, 1'b0, 13'h0010, 8'h00);
    run_cycle();

    // p1 write then p0 read of the same address
    set_p1(1'b1, 1'b1, 13'h1FFF, 8'h3C);
    run_cycle();
    set_p1(1'b0, 1'b0, 13'h0000, 8'h00);
    set_p0(1'b1, 1'b0, 13'h1FFF, 8'h00);
    run_cycle();
    set_p0(1'b0, 1'b0, 13'h0000, 8'h00);
    run_cycle();
    check("raw_data", 32'(ref_mem[13'h1FFF]), 32'h3C);

    // Continuous contention
    p1_gnt_count = 0;
    set_p0(1'b1, 1'b0, 13'h0020, 8'h00);
    set_p1(1'b1, 1'b0, 13'h0021, 8'h00);
    repeat (27) run_cycle();
    check("p1_gnt_rate", 32'(p1_gnt_count), FAIR ? 32'd3 : 32'd0);
    set_p0(1'b0, 1'b0, '0, 8'h00);
    run_cycle();
    check("p1_after_drop", 32'(g1_prev), 32'd1);
    set_p1(1'b0, 1'b0, '0, 8'h00);
    run_cycle();

    // Alternating reads
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        set_p0(1'b1, 1'b0, 13'(i), 8'h00);
        set_p1(1'b0, 1'b0, '0, 8'h00);
      end else begin
        set_p0(1'b0, 1'b0, '0, 8'h00);
        set_p1(1'b1, 1'b0, 13'(i), 8'h00);
      end
      run_cycle();
    end
    set_p0(1'b0, 1'b0, '0, 8'h00);
    set_p1(1'b0, 1'b0, '0, 8'h00);
    run_cycle();

    // Reset right after a p1 read grant, p0 write pending
    set_p1(1'b1, 1'b0, 13'h0042, 8'h00);
    run_cycle();
    set_p1(1'b0, 1'b0, '0, 8'h00);
    set_p0(1'b1, 1'b1, 13'h0042, 8'hEE);
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
    set_p0(1'b0, 1'b0, '0, 8'h00);
    run_cycle();

    // Random traffic honouring the hold-until-granted rule
    for (int c = 0; c < 400; c++) begin
      if (!(bus.p0_req && !g0_prev)) bus.p0_req = ($urandom_range(0, 3) != 0);
      if (!(bus.p1_req && !g1_prev)) bus.p1_req = ($urandom_range(0, 1) != 0);
      bus.p0_we    = ($urandom_range(0, 2) == 0);
      bus.p0_addr  = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15));
      bus.p0_wdata = 8'($urandom);
      bus.p1_we    = ($urandom_range(0, 1) == 0);
      bus.p1_addr  = 13'($urandom_range(0, 15));
      bus.p1_wdata = 8'($urandom);
      rst_n        = ($urandom_range(0, 49) != 0);
      run_cycle();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
